// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for an 8-bit-address accumulator datapath
//
// Sequences fetch / decode / execute for a datapath that holds AR, IR, PC, DR and AC
// registers and reads or writes a synchronous SRAM through AR.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-low reset
//   start     in   1   one-cycle pulse; starts execution at address 0x00 from IDLE or HALT
//   ir        in  16   datapath IR; opcode ir[15:12], operand address ir[7:0]
//   sel       out  3   bus source: 000 AR, 001 IR, 010 PC, 011 DR, 100 AC, 101 sram_dout, 111 none
//   load      out  6   one-hot destination: AR, IR, PC, DR, AC, SRAM write (bit 0..5); 0 = none
//   ar_out    out  8   registered address presented to the datapath AR input
//   busy      out  1   high in every state except IDLE and HALT
//   halted    out  1   high in HALT
//   illegal   out  1   sticky undefined-opcode flag, cleared by reset or start
//   instr_cnt out 16   retired-instruction counter, wraps
//
// MEM_WAIT (1..7) is the number of cycles between an ar_out change and valid
// sram_dout (or a settled write address).

module control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  output logic [2:0]  sel,
  output logic [5:0]  load,
  output logic [7:0]  ar_out,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FLOAD,
    S_DECODE,
    S_LDA_W,
    S_LDA,
    S_STA_W,
    S_STA,
    S_JMP,
    S_HALT
  } state_t;

  localparam logic [2:0] WLAST = 3'(MEM_WAIT - 1);

  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_SRAM = 3'b101;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [5:0] LD_IR   = 6'b000010;
  localparam logic [5:0] LD_PC   = 6'b000100;
  localparam logic [5:0] LD_AC   = 6'b010000;
  localparam logic [5:0] LD_SRAM = 6'b100000;
  localparam logic [5:0] LD_NONE = 6'b000000;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ar_q, ar_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        ill_q, ill_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [5:0]  load_q, load_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  // Only the opcode and operand address fields are meaningful to the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[11:8];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    wcnt_d  = wcnt_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 8'h00;
          ar_d    = 8'h00;
          ill_d   = 1'b0;
          wcnt_d  = 3'd0;
        end
      end

      S_FETCH: begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == WLAST) begin
          state_d = S_FLOAD;
          wcnt_d  = 3'd0;
        end
      end

      S_FLOAD: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        cnt_d  = cnt_q + 16'd1;
        wcnt_d = 3'd0;
        case (ir[15:12])
          4'h0: begin
            state_d = S_FETCH;
            ar_d    = pc_q;
          end
          4'h1: begin
            state_d = S_LDA_W;
            ar_d    = ir[7:0];
          end
          4'h2: begin
            state_d = S_STA_W;
            ar_d    = ir[7:0];
          end
          4'h3: begin
            // Target goes onto ar_out during the JMP cycle itself, so that
            // cycle already counts as the first memory-wait cycle of the fetch.
            state_d = S_JMP;
            pc_d    = ir[7:0];
            ar_d    = ir[7:0];
          end
          4'hF: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_FETCH;
            ar_d    = pc_q;
            ill_d   = 1'b1;
          end
        endcase
      end

      S_LDA_W, S_STA_W: begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == WLAST) begin
          state_d = (state_q == S_LDA_W) ? S_LDA : S_STA;
          wcnt_d  = 3'd0;
        end
      end

      S_LDA, S_STA: begin
        state_d = S_FETCH;
        ar_d    = pc_q;
        wcnt_d  = 3'd0;
      end

      S_JMP: begin
        if (MEM_WAIT == 1) begin
          state_d = S_FLOAD;
          wcnt_d  = 3'd0;
        end else begin
          state_d = S_FETCH;
          wcnt_d  = 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus controls are decoded from the next state so they line up with the
  // state register.
  always_comb begin
    sel_d    = SEL_NONE;
    load_d   = LD_NONE;
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
    case (state_d)
      S_FLOAD: begin
        sel_d  = SEL_SRAM;
        load_d = LD_IR;
      end
      S_LDA: begin
        sel_d  = SEL_SRAM;
        load_d = LD_AC;
      end
      S_STA: begin
        sel_d  = SEL_AC;
        load_d = LD_SRAM;
      end
      S_JMP: begin
        sel_d  = SEL_SRAM;
        load_d = LD_PC;
      end
      default: begin
        sel_d  = SEL_NONE;
        load_d = LD_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'h00;
      ar_q     <= 8'h00;
      wcnt_q   <= 3'd0;
      ill_q    <= 1'b0;
      cnt_q    <= 16'h0000;
      sel_q    <= SEL_NONE;
      load_q   <= LD_NONE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      wcnt_q   <= wcnt_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign sel       = sel_q;
  assign load      = load_q;
  assign ar_out    = ar_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = ill_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] ir;
  logic [2:0]  sel;
  logic [5:0]  load;
  logic [7:0]  ar_out;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_cnt;

  int checks;
  int errors;

  control_unit #(.MEM_WAIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ir        (ir),
    .sel       (sel),
    .load      (load),
    .ar_out    (ar_out),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] ir;
    logic [2:0]  sel;
    logic [5:0]  load;
    logic [7:0]  ar;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [15:0] i, input logic [2:0] s,
                     input logic [5:0] l, input logic [7:0] a, input logic b,
                     input logic h, input logic il, input logic [15:0] c);
    vec_t v;
    v.start = st; v.ir = i; v.sel = s; v.load = l; v.ar = a;
    v.busy = b; v.halted = h; v.illegal = il; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sel/load/ar/busy/halt/ill/cnt=%h want %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {sel, load, ar_out, busy, halted, illegal, instr_cnt};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ir    = 16'h0000;
    checks = 0;
    errors = 0;

    // Asynchronous reset, checked between clock edges.
    #2 rst = 1'b0;
    #1 check("reset_async", outs(), {3'b111, 6'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    check("idle_after_reset", outs(), {3'b111, 6'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});

    // Program: NOP, NOP, LDA 42, STA 10, JMP FF, NOP (wrap), illegal 5, HLT, restart.
    //  st  ir        sel     load       ar  bsy hlt ill cnt
    add(1, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd0); // 0 FETCH
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd0); // 1 FETCH
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h00, 1, 0, 0, 16'd0); // 2 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd0); // 3 DECODE
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 1, 0, 0, 16'd1); // 4 FETCH pc=1
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 1, 0, 0, 16'd1); // 5
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h01, 1, 0, 0, 16'd1); // 6 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 1, 0, 0, 16'd1); // 7 DECODE
    add(0, 16'h1042, 3'b111, 6'b000000, 8'h42, 1, 0, 0, 16'd2); // 8 LDA_W
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h42, 1, 0, 0, 16'd2); // 9 LDA_W
    add(0, 16'h0000, 3'b101, 6'b010000, 8'h42, 1, 0, 0, 16'd2); // 10 LDA
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h02, 1, 0, 0, 16'd2); // 11 FETCH
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h02, 1, 0, 0, 16'd2); // 12
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h02, 1, 0, 0, 16'd2); // 13 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h02, 1, 0, 0, 16'd2); // 14 DECODE
    add(0, 16'h2010, 3'b111, 6'b000000, 8'h10, 1, 0, 0, 16'd3); // 15 STA_W
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h10, 1, 0, 0, 16'd3); // 16 STA_W
    add(0, 16'h0000, 3'b100, 6'b100000, 8'h10, 1, 0, 0, 16'd3); // 17 STA
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h03, 1, 0, 0, 16'd3); // 18 FETCH
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h03, 1, 0, 0, 16'd3); // 19
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h03, 1, 0, 0, 16'd3); // 20 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h03, 1, 0, 0, 16'd3); // 21 DECODE
    add(0, 16'h30FF, 3'b101, 6'b000100, 8'hFF, 1, 0, 0, 16'd4); // 22 JMP
    add(0, 16'h0000, 3'b111, 6'b000000, 8'hFF, 1, 0, 0, 16'd4); // 23 FETCH
    add(0, 16'h0000, 3'b101, 6'b000010, 8'hFF, 1, 0, 0, 16'd4); // 24 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'hFF, 1, 0, 0, 16'd4); // 25 DECODE
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd5); // 26 FETCH wrap
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd5); // 27
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h00, 1, 0, 0, 16'd5); // 28 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd5); // 29 DECODE
    add(0, 16'h5000, 3'b111, 6'b000000, 8'h01, 1, 0, 1, 16'd6); // 30 illegal
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 1, 0, 1, 16'd6); // 31
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h01, 1, 0, 1, 16'd6); // 32 FLOAD
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 1, 0, 1, 16'd6); // 33 DECODE
    add(0, 16'hF000, 3'b111, 6'b000000, 8'h01, 0, 1, 1, 16'd7); // 34 HALT
    add(0, 16'h0000, 3'b111, 6'b000000, 8'h01, 0, 1, 1, 16'd7); // 35 HALT
    add(1, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd7); // 36 restart
    add(1, 16'h0000, 3'b111, 6'b000000, 8'h00, 1, 0, 0, 16'd7); // 37 start ignored
    add(0, 16'h0000, 3'b101, 6'b000010, 8'h00, 1, 0, 0, 16'd7); // 38 FLOAD

    foreach (vecs[i]) begin
      start = vecs[i].start;
      ir    = vecs[i].ir;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].sel, vecs[i].load, vecs[i].ar, vecs[i].busy,
             vecs[i].halted, vecs[i].illegal, vecs[i].cnt});
      checks++;
      if (!$onehot0(load)) begin
        errors++;
        $display("FAIL onehot_vec%0d: load=%b want at most one bit", i, load);
      end
    end
    start = 1'b0;

    // Reset during LDA_W: immediate return to reset values, then silence.
    rst = 1'b0; #1; @(negedge clk); rst = 1'b1;
    ir = 16'h1042;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) step();   // FETCH FLOAD DECODE LDA_W
    check("in_lda_w", outs(), {3'b111, 6'b0, 8'h42, 1'b1, 1'b0, 1'b0, 16'd1});
    #2 rst = 1'b0;
    #1 check("reset_in_lda_w", outs(), {3'b111, 6'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk); rst = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (load != 6'b0 || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL quiet_after_lda_reset: %0d active cycles want 0", bad);
      end
    end

    // Reset during the STA write cycle.
    ir = 16'h2010;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 6; k++) step();   // ... STA_W STA_W STA
    check("in_sta", outs(), {3'b100, 6'b100000, 8'h10, 1'b1, 1'b0, 1'b0, 16'd1});
    #2 rst = 1'b0;
    #1 check("reset_in_sta", outs(), {3'b111, 6'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk); rst = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (load != 6'b0 || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL quiet_after_sta_reset: %0d active cycles want 0", bad);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
